output_transmitter: RTL
=======================

# output_transmitter

Output-side link driver for one router port. It is the transmitting end of the 17-bit flit link whose receiving end is the neighbour's input buffer. The block accepts 16-bit payloads from the crossbar through a valid/ready handshake and queues them in a small FIFO. It drives them onto the link as registered 17-bit words with the valid flag in bit 16, and limits sends with a credit counter that mirrors free slots in the downstream buffer.

## Interface
- `FIFO_DEPTH`, 4: local queue entries; power of two, 2..16.
- `CREDITS`, 4: downstream buffer slots; initial and maximum credit count, 1..15.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `flit_i`  in  16  payload from crossbar.
- `flit_valid_i`  in  1  `flit_i` valid this cycle.
- `flit_ready_o`  out  1  queue can accept; equals !full, combinational from registered state only.
- `credit_i`  in  1  one-cycle pulse: downstream freed one slot (its send strobe).
- `link_o`  out  17  registered link word: bit 16 = valid, bits 15:0 = payload.
- `credit_count_o`  out  4  current credits.
- `credit_err_o`  out  1  sticky: credit returned while counter already at `CREDITS`.

## Operation
- Push: on an edge where `flit_valid_i && flit_ready_o`, the payload is written at the tail and `count` increments.
- Send condition, evaluated each cycle from registered state: `send = (count != 0) && (credits != 0)`.
- On an edge with `send`:
  - the head is popped;
  - `link_o <= {1'b1, head}`;
  - one credit is consumed.
- On an edge without `send`, `link_o <= 17'h00000`. The link never holds a stale valid word for more than one cycle.
- Credit update: `credits_next = credits - send + credit_i`.
  - If `credit_i` arrives with `credits == CREDITS` and no send, the credit is dropped, `credits` stays at `CREDITS`, and `credit_err_o` sets.
  - `credit_err_o` clears only on reset.
- Simultaneous `send` and `credit_i`: net change 0, no error, even at `credits == CREDITS`.
- Simultaneous push and pop:
  - allowed when not full; `count` is unchanged and pointers both advance;
  - when full, `flit_ready_o = 0` even if a pop occurs that edge. No push-through on full.
- Pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally. `count` is one bit wider, to distinguish full from empty.
- FIFO order is strict: flits leave in acceptance order, with no reordering or drops.
- `credit_i` is a strobe. Each cycle it is high counts as one credit.

## Timing
- Reset values (asynchronous assertion, effective immediately):
  - `link_o = 0`, `count = 0`, pointers `= 0`;
  - `credits = CREDITS`, `credit_count_o = CREDITS`;
  - `credit_err_o = 0`, `flit_ready_o = 1`.
- Reset mid-operation discards all queued flits and restores full credits. Flits in flight downstream are not tracked; the system resets both ends together.
- Latency: a flit accepted at edge k appears on `link_o` after edge k+1 at the earliest (empty queue, credits > 0). There is no same-edge bypass.
- Throughput: one flit per cycle while credits and data are available.
- A `credit_i` sampled at edge k enables a send decided in cycle k+1, so the link word appears after edge k+1.
- `credit_count_o` reflects the register and updates at the edge.
- `flit_ready_o` deasserts in the cycle after the edge that fills the queue. It reasserts in the cycle after the first pop from full.

## Test plan
- Reset/idle: assert `rst` mid-cycle -> outputs reach reset values immediately. Release with no input -> `link_o` stays `17'h00000` and `credit_count_o = 4` indefinitely.
- Single flit: push `16'hA5A5` at edge 0 -> `link_o = 17'h1A5A5` for exactly one cycle after edge 1, then `17'h00000`. `credit_count_o` goes 4 -> 3.
- Credit exhaustion: push 6 flits (1..6) back-to-back, no `credit_i` ->
  - flits 1..4 sent on consecutive cycles, credits reach 0;
  - flits 5, 6 are held;
  - pulse `credit_i` once -> flit 5 is sent one cycle later; then pulse again -> flit 6 is sent.
- Full FIFO: hold credits at 0 and push until `flit_ready_o = 0` after 4 accepts. A 5th valid is not accepted. Return credits -> order 1..4 is preserved on the link, and `ready` reasserts after the first pop.
- Credit overflow: at `credits = 4`, no data, pulse `credit_i` -> count stays 4 and `credit_err_o = 1`. A later send alone does not clear it; only `rst` does.
- Simultaneous: at `credits = 4` with data queued, `credit_i` arrives in the same cycle as a send -> count stays 4, `credit_err_o` stays 0. Wrap test: stream 20 flits with steady credits -> all arrive in order with no gaps.

Source files
------------

// File: rtl/output_transmitter.sv
// Credit-limited link driver: queues crossbar flits and sends them as registered {valid, payload} words.
// One-cycle minimum latency, one flit per cycle; flit_ready_o drops while the queue is full.
module output_transmitter #(
  parameter int FIFO_DEPTH = 4,
  parameter int CREDITS    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] flit_i,
  input  logic        flit_valid_i,
  output logic        flit_ready_o,
  input  logic        credit_i,
  output logic [16:0] link_o,
  output logic [3:0]  credit_count_o,
  output logic        credit_err_o
);
  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [3:0]  MAX_CRED = 4'(CREDITS);

  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [3:0]    credits_q, credits_d;
  logic          err_q, err_d;
  logic [16:0]   link_q, link_d;
  logic          push, send, overflow;

  // Ready is derived from registered occupancy only, so a pop cannot make room for a same-edge push.
  assign flit_ready_o = (count_q != FULL_CNT);
  assign push         = flit_valid_i && flit_ready_o;
  assign send         = (count_q != '0) && (credits_q != '0);
  assign overflow     = credit_i && !send && (credits_q == MAX_CRED);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    credits_d = credits_q;
    err_d     = err_q | overflow;
    link_d    = '0;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (send) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      link_d   = {1'b1, mem_q[rd_ptr_q]};
    end

    case ({push, send})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    if (send && !credit_i)
      credits_d = credits_q - 4'd1;
    else if (!send && credit_i && !overflow)
      credits_d = credits_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= flit_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      credits_q <= MAX_CRED;
      err_q     <= 1'b0;
      link_q    <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      credits_q <= credits_d;
      err_q     <= err_d;
      link_q    <= link_d;
    end
  end

  assign link_o         = link_q;
  assign credit_count_o = credits_q;
  assign credit_err_o   = err_q;
endmodule
